// File: rtl/hazard_dest_tracker.sv
// Write-back destination pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall detection.
// Optional macro MEM_WAIT_EN: freeze the pipeline while a load in EX/MEM waits on mem_ready.
module hazard_dest_tracker #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] IFIDrsaddr,
  input  logic [ADDR_W-1:0] IFIDrtaddr,
  input  logic              id_uses_rt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [ADDR_W-1:0] id_regdst,
  input  logic              flush_i,
  input  logic              mem_ready,
  output logic              IDEXmemread,
  output logic [ADDR_W-1:0] IDEXregdst,
  output logic              EXMEMregwrite,
  output logic [ADDR_W-1:0] EXMEMregdst,
  output logic              MEMWBregwrite,
  output logic [ADDR_W-1:0] MEMWBregdst,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              idex_rw_q,  idex_rw_d;
  logic              idex_mr_q,  idex_mr_d;
  logic [ADDR_W-1:0] idex_dst_q, idex_dst_d;
  logic              exmem_rw_q,  exmem_rw_d;
  logic [ADDR_W-1:0] exmem_dst_q, exmem_dst_d;
  logic              memwb_rw_q,  memwb_rw_d;
  logic [ADDR_W-1:0] memwb_dst_q, memwb_dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic luh_c;
  logic freeze_c;
  logic stall_c;

`ifdef MEM_WAIT_EN
  logic exmem_mr_q, exmem_mr_d;

  assign freeze_c = exmem_mr_q & ~mem_ready;
`else
  logic unused_mem_ready;

  assign unused_mem_ready = mem_ready;
  assign freeze_c         = 1'b0;
`endif

  // Load in ID/EX whose nonzero destination is read by the ID instruction.
  always_comb begin
    luh_c = 1'b0;
    if (idex_mr_q && (idex_dst_q != '0)) begin
      luh_c = (idex_dst_q == IFIDrsaddr) ||
              (id_uses_rt && (idex_dst_q == IFIDrtaddr));
    end
  end

  // Freeze overrides flush; flush suppresses a load-use stall.
  always_comb begin
    stall_c = 1'b0;
    if (!rst_i) begin
      stall_c = freeze_c | (luh_c & ~flush_i);
    end
  end

  assign stall_o = stall_c;

  // Next-state for stage registers and stall counter.
  always_comb begin
    idex_rw_d   = id_regwrite;
    idex_mr_d   = id_memread;
    idex_dst_d  = id_regdst;
    exmem_rw_d  = idex_rw_q;
    exmem_dst_d = idex_dst_q;
    memwb_rw_d  = exmem_rw_q;
    memwb_dst_d = exmem_dst_q;
    cnt_d       = cnt_q;
`ifdef MEM_WAIT_EN
    exmem_mr_d  = idex_mr_q;
`endif

    if (freeze_c) begin
      idex_rw_d   = idex_rw_q;
      idex_mr_d   = idex_mr_q;
      idex_dst_d  = idex_dst_q;
      exmem_rw_d  = exmem_rw_q;
      exmem_dst_d = exmem_dst_q;
      memwb_rw_d  = memwb_rw_q;
      memwb_dst_d = memwb_dst_q;
`ifdef MEM_WAIT_EN
      exmem_mr_d  = exmem_mr_q;
`endif
    end else if (flush_i || luh_c) begin
      idex_rw_d  = 1'b0;
      idex_mr_d  = 1'b0;
      idex_dst_d = '0;
    end

    if (stall_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_rw_q   <= 1'b0;
      idex_mr_q   <= 1'b0;
      idex_dst_q  <= '0;
      exmem_rw_q  <= 1'b0;
      exmem_dst_q <= '0;
      memwb_rw_q  <= 1'b0;
      memwb_dst_q <= '0;
      cnt_q       <= '0;
`ifdef MEM_WAIT_EN
      exmem_mr_q  <= 1'b0;
`endif
    end else begin
      idex_rw_q   <= idex_rw_d;
      idex_mr_q   <= idex_mr_d;
      idex_dst_q  <= idex_dst_d;
      exmem_rw_q  <= exmem_rw_d;
      exmem_dst_q <= exmem_dst_d;
      memwb_rw_q  <= memwb_rw_d;
      memwb_dst_q <= memwb_dst_d;
      cnt_q       <= cnt_d;
`ifdef MEM_WAIT_EN
      exmem_mr_q  <= exmem_mr_d;
`endif
    end
  end

  // ID/EX regwrite is tracked only so it can flow into EX/MEM.
  assign IDEXmemread   = idex_mr_q;
  assign IDEXregdst    = idex_dst_q;
  assign EXMEMregwrite = exmem_rw_q;
  assign EXMEMregdst   = exmem_dst_q;
  assign MEMWBregwrite = memwb_rw_q;
  assign MEMWBregdst   = memwb_dst_q;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Directed bench for hazard_dest_tracker (CNT_W=4 to reach counter saturation quickly).
module tb_hazard_dest_tracker;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [ADDR_W-1:0] IFIDrsaddr = '0;
  logic [ADDR_W-1:0] IFIDrtaddr = '0;
  logic              id_uses_rt = 1'b0;
  logic              id_regwrite = 1'b0;
  logic              id_memread = 1'b0;
  logic [ADDR_W-1:0] id_regdst = '0;
  logic              flush_i = 1'b0;
  logic              mem_ready = 1'b1;
  logic              IDEXmemread;
  logic [ADDR_W-1:0] IDEXregdst;
  logic              EXMEMregwrite;
  logic [ADDR_W-1:0] EXMEMregdst;
  logic              MEMWBregwrite;
  logic [ADDR_W-1:0] MEMWBregdst;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_dest_tracker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IFIDrsaddr(IFIDrsaddr), .IFIDrtaddr(IFIDrtaddr), .id_uses_rt(id_uses_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_regdst(id_regdst),
    .flush_i(flush_i), .mem_ready(mem_ready),
    .IDEXmemread(IDEXmemread), .IDEXregdst(IDEXregdst),
    .EXMEMregwrite(EXMEMregwrite), .EXMEMregdst(EXMEMregdst),
    .MEMWBregwrite(MEMWBregwrite), .MEMWBregdst(MEMWBregdst),
    .stall_o(stall_o), .stall_cnt(stall_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic rw, input logic mr, input logic [ADDR_W-1:0] dst,
                        input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                        input logic urt);
    id_regwrite = rw; id_memread = mr; id_regdst = dst;
    IFIDrsaddr = rs; IFIDrtaddr = rt; id_uses_rt = urt;
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    flush_i = 1'b0; mem_ready = 1'b1;
    set_id(1'b0, 1'b0, '0, '0, '0, 1'b0);
    #2 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    set_id(1'b1, 1'b1, 5'd6, '0, '0, 1'b0);
    tick();
    set_id(1'b1, 1'b0, 5'd7, 5'd6, '0, 1'b0);
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({IDEXmemread, IDEXregdst, EXMEMregwrite, EXMEMregdst, MEMWBregwrite, MEMWBregdst,
         stall_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got idex=%0d/%0d exmem=%0d/%0d memwb=%0d/%0d stall=%0d want all 0",
               IDEXmemread, IDEXregdst, EXMEMregwrite, EXMEMregdst, MEMWBregwrite, MEMWBregdst,
               stall_o);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    set_id(1'b1, 1'b0, 5'd11, '0, '0, 1'b0);
    #1 rst_i = 1'b0;
    tick();
    checks++;
    if (IDEXregdst !== 5'd11) begin
      errors++;
      $display("FAIL reset_release_load: got IDEXregdst=%0d want 11", IDEXregdst);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 1'b1, 5'd8, 5'd1, 5'd2, 1'b1);
    tick();
    set_id(1'b1, 1'b0, 5'd10, 5'd8, 5'd3, 1'b1);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall_on: got %0d want 1", stall_o);
    end
    tick();
    checks++;
    if ({stall_o, IDEXregdst, EXMEMregdst, EXMEMregwrite} !== {1'b0, 5'd0, 5'd8, 1'b1}) begin
      errors++;
      $display("FAIL lu_after_stall: got stall=%0d idex=%0d exmem=%0d rw=%0d want 0 0 8 1",
               stall_o, IDEXregdst, EXMEMregdst, EXMEMregwrite);
    end
    tick();
    checks++;
    if ({MEMWBregdst, MEMWBregwrite, IDEXregdst, stall_cnt} !== {5'd8, 1'b1, 5'd10, 4'd1}) begin
      errors++;
      $display("FAIL lu_resume: got memwb=%0d rw=%0d idex=%0d cnt=%0d want 8 1 10 1",
               MEMWBregdst, MEMWBregwrite, IDEXregdst, stall_cnt);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_id(1'b1, 1'b1, 5'd0, 5'd4, 5'd5, 1'b0);
    tick();
    set_id(1'b1, 1'b0, 5'd12, 5'd0, 5'd0, 1'b1);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL lw_r0_no_stall: got %0d want 0", stall_o);
    end
    set_id(1'b1, 1'b1, 5'd9, 5'd4, 5'd5, 1'b0);
    tick();
    set_id(1'b1, 1'b0, 5'd13, 5'd3, 5'd9, 1'b0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rt_unused_no_stall: got %0d want 0", stall_o);
    end
    set_id(1'b1, 1'b0, 5'd13, 5'd3, 5'd9, 1'b1);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rt_used_stall: got %0d want 1", stall_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 1'b1, 5'd5, 5'd1, 5'd1, 1'b0);
    tick();
    set_id(1'b1, 1'b0, 5'd14, 5'd5, 5'd0, 1'b0);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_suppress: got stall=%0d want 0", stall_o);
    end
    tick();
    flush_i = 1'b0;
    checks++;
    if ({IDEXmemread, IDEXregdst, EXMEMregdst, stall_cnt} !== {1'b0, 5'd0, 5'd5, 4'd0}) begin
      errors++;
      $display("FAIL flush_bubble: got idexmr=%0d idex=%0d exmem=%0d cnt=%0d want 0 0 5 0",
               IDEXmemread, IDEXregdst, EXMEMregdst, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_id(1'b1, 1'b0, ADDR_W'(i), 5'd20, 5'd21, 1'b1);
      tick();
    end
    checks++;
    if ({IDEXregdst, EXMEMregdst, MEMWBregdst} !== {5'd3, 5'd2, 5'd1}) begin
      errors++;
      $display("FAIL b2b_pipe: got idex=%0d exmem=%0d memwb=%0d want 3 2 1",
               IDEXregdst, EXMEMregdst, MEMWBregdst);
    end
    set_id(1'b1, 1'b0, 5'd0, 5'd20, 5'd21, 1'b1);
    tick();
    set_id(1'b0, 1'b0, 5'd0, 5'd20, 5'd21, 1'b0);
    tick();
    checks++;
    if ({EXMEMregwrite, EXMEMregdst, MEMWBregdst} !== {1'b1, 5'd0, 5'd3}) begin
      errors++;
      $display("FAIL b2b_dst0: got exmemrw=%0d exmem=%0d memwb=%0d want 1 0 3",
               EXMEMregwrite, EXMEMregdst, MEMWBregdst);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_id(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (stall_o !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL sat_stall_pattern: cycle %0d got %0d want %0d", i, stall_o, (i % 2) == 1);
      end
      tick();
      if (i == 19) begin
        checks++;
        if (stall_cnt !== 4'd10) begin
          errors++;
          $display("FAIL sat_mid_cnt: got %0d want 10", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want 15", stall_cnt);
    end
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    do_reset();
    set_id(1'b1, 1'b1, 5'd4, 5'd1, 5'd1, 1'b0);
    tick();
    mem_ready = 1'b0;
    set_id(1'b0, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0);
    tick();
    set_id(1'b1, 1'b0, 5'd12, 5'd2, 5'd2, 1'b0);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL mw_stall: got %0d want 1", stall_o);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({IDEXregdst, EXMEMregdst, MEMWBregdst, stall_cnt} !== {5'd0, 5'd4, 5'd0, 4'd3}) begin
      errors++;
      $display("FAIL mw_frozen: got idex=%0d exmem=%0d memwb=%0d cnt=%0d want 0 4 0 3",
               IDEXregdst, EXMEMregdst, MEMWBregdst, stall_cnt);
    end
    flush_i = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mw_release_stall: got %0d want 0", stall_o);
    end
    tick();
    checks++;
    if ({IDEXregdst, MEMWBregdst, stall_cnt} !== {5'd12, 5'd4, 4'd3}) begin
      errors++;
      $display("FAIL mw_resume: got idex=%0d memwb=%0d cnt=%0d want 12 4 3",
               IDEXregdst, MEMWBregdst, stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_back_to_back();
    test_saturation();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
